// File: rtl/regfile_read_sb.sv
// regfile_read_sb: 32 x XLEN register file with a pending-write scoreboard.
//
// Decode issues an rs1/rs2 read request. The operands are returned only once
// neither source has an older in-flight write outstanding. The WB stage
// writes results back and clears their pending bits. The issue logic marks
// destinations as pending.
//
// Parameters:
//   XLEN  data width of each register
//   AW    register address width (2**AW registers, x0 hardwired to zero)
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   req_valid  decode presents a read request
//   req_ready  block can accept a request (IDLE only)
//   rs1_addr   source 1 index, sampled on acceptance
//   rs2_addr   source 2 index, sampled on acceptance
//   rsp_valid  rs1_data/rs2_data valid; held until rsp_ack
//   rsp_ack    consumer has taken the response
//   rs1_data   source 1 operand
//   rs2_data   source 2 operand
//   mark_en    set pending bit of mark_addr
//   mark_addr  destination being marked
//   wb_en      write wb_data to wb_addr and clear its pending bit
//   wb_addr    writeback destination
//   wb_data    writeback value
//
// Configuration macro:
//   REGFILE_RESET_EN  when defined, rst_n also clears the register contents.
//                     When undefined, only control state, the scoreboard and
//                     the outputs are reset, so the array can map to a RAM.

module regfile_read_sb #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic            rsp_valid,
  input  logic            rsp_ack,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            mark_en,
  input  logic [AW-1:0]   mark_addr,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data
);

  localparam int unsigned NumRegs = 2 ** AW;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        rs1_q, rs1_d;
  logic [AW-1:0]        rs2_q, rs2_d;
  logic [XLEN-1:0]      rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]      rs2_data_q, rs2_data_d;
  logic [NumRegs-1:0]   pending_q, pending_d;
  logic [XLEN-1:0]      regs_q [NumRegs];

  // Source addresses under evaluation: live inputs while idle, latched ones
  // while waiting.
  logic [AW-1:0]   src1, src2;
  logic            src1_clear, src2_clear;
  logic            src1_byp, src2_byp;
  logic [XLEN-1:0] src1_val, src2_val;

  always_comb begin
    src1 = (state_q == StIdle) ? rs1_addr : rs1_q;
    src2 = (state_q == StIdle) ? rs2_addr : rs2_q;
  end

  // A writeback to the source in the same cycle both clears the hazard and
  // supplies the operand directly.
  always_comb begin
    src1_byp   = wb_en && (wb_addr == src1);
    src2_byp   = wb_en && (wb_addr == src2);
    src1_clear = (src1 == '0) || !pending_q[src1] || src1_byp;
    src2_clear = (src2 == '0) || !pending_q[src2] || src2_byp;
  end

  always_comb begin
    if (src1 == '0) begin
      src1_val = '0;
    end else if (src1_byp) begin
      src1_val = wb_data;
    end else begin
      src1_val = regs_q[src1];
    end
    if (src2 == '0) begin
      src2_val = '0;
    end else if (src2_byp) begin
      src2_val = wb_data;
    end else begin
      src2_val = regs_q[src2];
    end
  end

  // Request FSM next state and operand capture.
  always_comb begin
    state_d    = state_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          rs1_d = rs1_addr;
          rs2_d = rs2_addr;
          if (src1_clear && src2_clear) begin
            state_d    = StResp;
            rs1_data_d = src1_val;
            rs2_data_d = src2_val;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (src1_clear && src2_clear) begin
          state_d    = StResp;
          rs1_data_d = src1_val;
          rs2_data_d = src2_val;
        end
      end
      StResp: begin
        if (rsp_ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Scoreboard: a mark in the same cycle as a writeback to the same register
  // belongs to a younger producer, so it is applied last and wins.
  always_comb begin
    pending_d = pending_q;
    if (wb_en) begin
      pending_d[wb_addr] = 1'b0;
    end
    if (mark_en && (mark_addr != '0)) begin
      pending_d[mark_addr] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      pending_q  <= '0;
    end else begin
      state_q    <= state_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      pending_q  <= pending_d;
    end
  end

  // Register array; entry 0 is never written and never read as data.
`ifdef REGFILE_RESET_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_en && (wb_addr != '0)) begin
      regs_q[wb_addr] <= wb_data;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (wb_en && (wb_addr != '0)) begin
      regs_q[wb_addr] <= wb_data;
    end
  end
`endif

  always_comb begin
    req_ready = (state_q == StIdle);
    rsp_valid = (state_q == StResp);
    rs1_data  = rs1_data_q;
    rs2_data  = rs2_data_q;
  end

  // A response must hold, data included, until it is acknowledged.
  a_rsp_hold: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_valid && !rsp_ack |=> rsp_valid && $stable(rs1_data) && $stable(rs2_data));

  a_x0_never_pending: assert property (@(posedge clk) disable iff (!rst_n)
    !pending_q[0]);

endmodule

// File: tb/tb_regfile_read_sb.sv
module tb_regfile_read_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rsp_valid;
  logic        rsp_ack;
  logic [31:0] rs1_data, rs2_data;
  logic        mark_en;
  logic [4:0]  mark_addr;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_read_sb #(.XLEN(32), .AW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rsp_valid (rsp_valid),
    .rsp_ack   (rsp_ack),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .mark_en   (mark_en),
    .mark_addr (mark_addr),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled at the negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Table of single read transactions. byp=0: write one cycle before the
  // request; byp=1: write in the same cycle as the accept.
  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
    bit          byp;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vec [6];

  // Reference model: architectural register values, pending set and one
  // outstanding transaction.
  logic [31:0] m_regs [32];
  logic [31:0] m_pend;
  bit          m_req, m_rsp;
  logic [4:0]  m_a1, m_a2;
  logic [31:0] m_d1, m_d2;

  function automatic bit m_clear(input logic [4:0] a);
    return (a == 0) || !m_pend[a] || (wb_en && wb_addr == a);
  endfunction

  function automatic logic [31:0] m_val(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (wb_en && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  logic [31:0] held1, held2;

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    rs1_addr  = '0;
    rs2_addr  = '0;
    rsp_ack   = 1'b0;
    mark_en   = 1'b0;
    mark_addr = '0;
    wb_en     = 1'b0;
    wb_addr   = '0;
    wb_data   = '0;

    vec[0] = '{5'd5,  32'hDEADBEEF, 1'b0, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
    vec[1] = '{5'd7,  32'h12345678, 1'b1, 5'd7,  5'd7,  32'h12345678, 32'h12345678};
    vec[2] = '{5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
    vec[3] = '{5'd31, 32'h0BADF00D, 1'b1, 5'd5,  5'd31, 32'hDEADBEEF, 32'h0BADF00D};
    vec[4] = '{5'd12, 32'h11112222, 1'b0, 5'd12, 5'd7,  32'h11112222, 32'h12345678};
    vec[5] = '{5'd0,  32'h55555555, 1'b1, 5'd0,  5'd12, 32'h0,        32'h11112222};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("reset rsp_valid", 32'(rsp_valid), 0);
    check("reset req_ready", 32'(req_ready), 1);
    check("reset rs1_data", rs1_data, 0);
    check("reset rs2_data", rs2_data, 0);

    // Table-driven reads, latency 1 with clear sources.
    for (int i = 0; i < 6; i++) begin
      if (!vec[i].byp) begin
        wb_en = 1'b1; wb_addr = vec[i].wa; wb_data = vec[i].wd;
        tick();
        wb_en = 1'b0;
      end
      req_valid = 1'b1; rs1_addr = vec[i].r1; rs2_addr = vec[i].r2;
      if (vec[i].byp) begin
        wb_en = 1'b1; wb_addr = vec[i].wa; wb_data = vec[i].wd;
      end
      check($sformatf("vec%0d req_ready", i), 32'(req_ready), 1);
      tick();
      req_valid = 1'b0; wb_en = 1'b0;
      check($sformatf("vec%0d rsp_valid", i), 32'(rsp_valid), 1);
      check($sformatf("vec%0d rs1_data", i), rs1_data, vec[i].e1);
      check($sformatf("vec%0d rs2_data", i), rs2_data, vec[i].e2);
      rsp_ack = 1'b1;
      tick();
      rsp_ack = 1'b0;
      check($sformatf("vec%0d rsp drop", i), 32'(rsp_valid), 0);
    end

    // Hazard stall on x3, then ack hold.
    mark_en = 1'b1; mark_addr = 5'd3;
    tick();
    mark_en = 1'b0;
    req_valid = 1'b1; rs1_addr = 5'd3; rs2_addr = 5'd0;
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("stall rsp_valid", 32'(rsp_valid), 0);
      check("stall req_ready", 32'(req_ready), 0);
      tick();
    end
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hA5A5A5A5;
    check("stall before wb", 32'(rsp_valid), 0);
    tick();
    wb_en = 1'b0;
    check("stall release rsp_valid", 32'(rsp_valid), 1);
    check("stall release rs1", rs1_data, 32'hA5A5A5A5);
    check("stall release rs2", rs2_data, 32'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("hold rsp_valid", 32'(rsp_valid), 1);
      check("hold rs1", rs1_data, 32'hA5A5A5A5);
      check("hold req_ready", 32'(req_ready), 0);
    end
    rsp_ack = 1'b1;
    tick();
    rsp_ack = 1'b0;
    check("ack rsp_valid", 32'(rsp_valid), 0);
    check("ack req_ready", 32'(req_ready), 1);

    // Mark and writeback on x9 in the same cycle: mark wins.
    mark_en = 1'b1; mark_addr = 5'd9;
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h00000099;
    tick();
    mark_en = 1'b0; wb_en = 1'b0;
    req_valid = 1'b1; rs1_addr = 5'd9; rs2_addr = 5'd12;
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("mark-wins rsp_valid", 32'(rsp_valid), 0);
      tick();
    end
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h9999AAAA;
    tick();
    wb_en = 1'b0;
    check("mark-wins release", 32'(rsp_valid), 1);
    check("mark-wins rs1", rs1_data, 32'h9999AAAA);
    check("mark-wins rs2", rs2_data, 32'h11112222);
    rsp_ack = 1'b1;
    tick();
    rsp_ack = 1'b0;

    // Reset while waiting on x5.
    mark_en = 1'b1; mark_addr = 5'd5;
    tick();
    mark_en = 1'b0;
    req_valid = 1'b1; rs1_addr = 5'd5; rs2_addr = 5'd0;
    tick();
    req_valid = 1'b0;
    check("pre-reset wait", 32'(rsp_valid), 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid-reset rsp_valid", 32'(rsp_valid), 0);
    check("mid-reset req_ready", 32'(req_ready), 1);
    check("mid-reset rs1_data", rs1_data, 0);
    tick();
    check("post-reset idle", 32'(rsp_valid), 0);
    req_valid = 1'b1; rs1_addr = 5'd5; rs2_addr = 5'd0;
    tick();
    req_valid = 1'b0;
    check("post-reset pending clear", 32'(rsp_valid), 1);
`ifdef REGFILE_RESET_EN
    check("post-reset x5", rs1_data, 32'h0);
`else
    check("post-reset x5", rs1_data, 32'hDEADBEEF);
`endif
    rsp_ack = 1'b1;
    tick();
    rsp_ack = 1'b0;

    // Randomized phase: define every register first, then random traffic.
    m_pend = '0;
    m_regs[0] = '0;
    for (int a = 1; a < 32; a++) begin
      wb_en = 1'b1; wb_addr = 5'(a); wb_data = $urandom;
      m_regs[a] = wb_data;
      tick();
    end
    wb_en = 1'b0;
    m_req = 1'b0;
    m_rsp = 1'b0;
    m_a1 = '0; m_a2 = '0; m_d1 = '0; m_d2 = '0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      check("rand req_ready", 32'(req_ready), 32'(!m_req && !m_rsp));
      check("rand rsp_valid", 32'(rsp_valid), 32'(m_rsp));
      if (m_rsp) begin
        check("rand rs1_data", rs1_data, m_d1);
        check("rand rs2_data", rs2_data, m_d2);
      end

      req_valid = ($urandom_range(1, 0) == 1);
      rs1_addr  = 5'($urandom);
      rs2_addr  = 5'($urandom);
      rsp_ack   = ($urandom_range(2, 0) == 0);
      mark_en   = ($urandom_range(3, 0) == 0);
      mark_addr = 5'($urandom_range(31, 1));
      wb_en     = ($urandom_range(9, 0) < 6);
      wb_addr   = 5'($urandom);
      wb_data   = $urandom;

      if (!m_req && !m_rsp) begin
        if (req_valid) begin
          m_a1 = rs1_addr;
          m_a2 = rs2_addr;
          if (m_clear(m_a1) && m_clear(m_a2)) begin
            m_rsp = 1'b1;
            m_d1  = m_val(m_a1);
            m_d2  = m_val(m_a2);
          end else begin
            m_req = 1'b1;
          end
        end
      end else if (m_req) begin
        if (m_clear(m_a1) && m_clear(m_a2)) begin
          m_req = 1'b0;
          m_rsp = 1'b1;
          m_d1  = m_val(m_a1);
          m_d2  = m_val(m_a2);
        end
      end else if (rsp_ack) begin
        m_rsp = 1'b0;
      end

      if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
      if (wb_en) m_pend[wb_addr] = 1'b0;
      if (mark_en) m_pend[mark_addr] = 1'b1;

      tick();
    end

    req_valid = 1'b0; mark_en = 1'b0; wb_en = 1'b0; rsp_ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
